// File: rtl/commit_trace_buf.sv
// Retire-side commit trace FIFO with stop-PC / cycle-budget run control.
// Define TRACE_WRAP_EN to overwrite the oldest entry on overflow instead of dropping the newest.
module commit_trace_buf #(
  parameter int          DEPTH      = 16,
  parameter logic [31:0] STOP_PC    = 32'h0000_0198,
  parameter int          MAX_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       commit_valid,
  input  logic [31:0]                commit_pc,
  input  logic [31:0]                commit_instr,
  input  logic [4:0]                 commit_rd,
  input  logic                       commit_we,
  input  logic [31:0]                commit_wdata,
  input  logic                       rd_en,
  output logic [31:0]                trace_pc,
  output logic [31:0]                trace_instr,
  output logic [4:0]                 trace_rd,
  output logic                       trace_we,
  output logic [31:0]                trace_wdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       halted,
  output logic                       timeout,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [31:0]   CYC_LAST = 32'(MAX_CYCLES - 1);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
  localparam logic [1:0] ST_TOUT = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] wdata;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head_q, head_d, new_ent;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      state_q, state_d;
  logic [31:0]     cyc_q, cyc_d;
  logic            ovf_q, ovf_d;
  logic            running, push, pop, full_w, empty_w, stop_hit, wr_en, head_upd;

  always_comb begin
    new_ent  = '{pc: commit_pc, instr: commit_instr, rd: commit_rd,
                 we: commit_we, wdata: commit_wdata};
    running  = (state_q == ST_RUN);
    empty_w  = (count_q == '0);
    full_w   = (count_q == FULL_CNT);
    push     = commit_valid && running;
    pop      = rd_en && !empty_w;
    stop_hit = push && (commit_pc == STOP_PC);

    wr_en    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push && full_w && !pop) begin
      ovf_d = 1'b1;
`ifdef TRACE_WRAP_EN
      // Overwrite the oldest slot; count stays at DEPTH.
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      rd_ptr_d = rd_ptr_q + 1'b1;
`endif
    end else begin
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end

    // Head register gives fall-through output and holds its value once drained.
    // A new head that is being written this cycle is bypassed from the input.
    head_upd = (rd_ptr_d != rd_ptr_q) || empty_w;
    head_d   = head_q;
    if (head_upd && count_d != '0)
      head_d = (wr_en && rd_ptr_d == wr_ptr_q) ? new_ent : mem_q[rd_ptr_d];

    state_d = state_q;
    cyc_d   = cyc_q;
    if (running) begin
      cyc_d = cyc_q + 32'd1;
      if (stop_hit)               state_d = ST_HALT;
      else if (cyc_q == CYC_LAST) state_d = ST_TOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      head_q   <= '0;
      state_q  <= ST_RUN;
      cyc_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
      state_q  <= state_d;
      cyc_q    <= cyc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && wr_en) mem_q[wr_ptr_q] <= new_ent;
  end

  assign trace_pc    = head_q.pc;
  assign trace_instr = head_q.instr;
  assign trace_rd    = head_q.rd;
  assign trace_we    = head_q.we;
  assign trace_wdata = head_q.wdata;
  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign count       = count_q;
  assign halted      = (state_q == ST_HALT);
  assign timeout     = (state_q == ST_TOUT);
  assign overflow    = ovf_q;
endmodule
